// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared CPU types and constants (IM geometry, PC type, fetch state encoding)
package mips_cpu_pkg;
  localparam int IM_DEPTH = 1024;
  typedef logic [$clog2(IM_DEPTH)-1:0] im_addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] pc_t;
  localparam inst_t ZERO = '0;
  localparam pc_t PC_INC = 32'd4;
  localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic {IF_RUN, IF_HALT} if_state_e;
endpackage

// File: rtl/if_pc_gen.sv
// if_pc_gen: instruction-fetch PC generator driving the IM address/enable with delay-slot redirects
//   cpu_clk_50M/cpu_rst      clock, async active-high reset
//   stall                    freeze fetch (pc, id_pc, id_valid hold; redirect deferred)
//   redirect_valid/_target   jump or taken-branch destination from ID
//   imce/imaddr_d4/imwe/imdin  IM port (read-only use)
//   pc                       address presented to IM this cycle
//   id_pc/id_valid           PC and validity of the instruction IM is returning
//   fetch_err                sticky misaligned-redirect flag
// Optional: define ALIGN_CHK_EN to halt fetch on a misaligned redirect target.
module if_pc_gen
  import mips_cpu_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT,
  parameter int  IM_AW    = $clog2(IM_DEPTH)
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             imce,
  output logic [IM_AW-1:0] imaddr_d4,
  output logic             imwe,
  output logic [31:0]      imdin,
  output logic [31:0]      pc,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic             fetch_err
);
  if_state_e r_state, w_state_nx;
  pc_t r_pc, r_id_pc, w_pc_nx;
  logic r_id_valid, r_fetch_err, w_fetch, w_misalign;
`ifdef ALIGN_CHK_EN
  assign w_misalign = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_fetch = (r_state == IF_RUN) && !stall && !cpu_rst;
  // A redirect raised while fetching the delay slot only steers the following fetch.
  assign w_pc_nx = redirect_valid ? redirect_target : r_pc + PC_INC;
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst)
    if (cpu_rst) r_state <= IF_RUN;
    else r_state <= w_state_nx;
  always_comb w_state_nx = (w_fetch && w_misalign) ? IF_HALT : r_state;
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst)
    if (cpu_rst) begin
      r_pc        <= RESET_PC;
      r_id_pc     <= '0;
      r_id_valid  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else if (w_fetch) begin
      r_pc        <= w_pc_nx;
      r_id_pc     <= r_pc;
      r_id_valid  <= 1'b1;
      r_fetch_err <= r_fetch_err | w_misalign;
    end else if (r_state == IF_HALT) begin
      r_id_valid  <= 1'b0;
    end
  always_comb begin
    imce      = w_fetch;
    imaddr_d4 = r_pc[IM_AW+1:2];
    imwe      = 1'b0;
    imdin     = ZERO;
    pc        = r_pc;
    id_pc     = r_id_pc;
    id_valid  = r_id_valid;
    fetch_err = r_fetch_err;
  end
endmodule

// File: tb/tb_if_pc_gen.sv
// tb_if_pc_gen: scoreboard bench for if_pc_gen against a rule-level fetch model
module tb_if_pc_gen;
  import mips_cpu_pkg::*;
  localparam int AW = $clog2(IM_DEPTH);
  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        err;
  } exp_t;
  logic cpu_clk_50M = 1'b0, cpu_rst, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic imce, imwe, id_valid, fetch_err;
  logic [AW-1:0] imaddr_d4;
  logic [31:0] imdin, pc, id_pc;
  int total = 0, bad = 0;
  exp_t q[$];
  logic [31:0] m_pc, m_id_pc;
  logic m_id_valid, m_halt, m_err;

  if_pc_gen dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imce(imce), .imaddr_d4(imaddr_d4), .imwe(imwe), .imdin(imdin),
    .pc(pc), .id_pc(id_pc), .id_valid(id_valid), .fetch_err(fetch_err)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC_DEFAULT;
    m_id_pc = 32'h0;
    m_id_valid = 1'b0;
    m_halt = 1'b0;
    m_err = 1'b0;
  endtask

  // One cycle: drive inputs, check the combinational IM port, predict the edge.
  task automatic step(input logic s, input logic rv, input logic [31:0] t);
    logic go;
    logic [31:0] a;
    @(negedge cpu_clk_50M);
    stall = s;
    redirect_valid = rv;
    redirect_target = t;
    #1;
    go = !m_halt && !s;
    a = m_pc >> 2;
    chk("imce", 32'(imce), 32'(go));
    chk("imaddr", 32'(imaddr_d4), a % IM_DEPTH);
    chk("imwe", 32'(imwe), 32'h0);
    chk("imdin", imdin, 32'h0);
    if (go) begin
      m_id_pc = m_pc;
      m_id_valid = 1'b1;
      m_pc = rv ? t : m_pc + 32'd4;
`ifdef ALIGN_CHK_EN
      if (rv && (t % 4 != 0)) begin
        m_err = 1'b1;
        m_halt = 1'b1;
      end
`endif
    end else if (m_halt) m_id_valid = 1'b0;
    q.push_back('{m_pc, m_id_pc, m_id_valid, m_err});
  endtask

  task automatic check_reset_state();
    chk("rst_pc", pc, RESET_PC_DEFAULT);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    chk("rst_imce", 32'(imce), 32'h0);
  endtask

  // Reset asserted and released off the clock edges.
  task automatic pulse_reset();
    @(negedge cpu_clk_50M);
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0400;
    #4 cpu_rst = 1'b1;
    q.delete();
    model_reset();
    #1 check_reset_state();
    stall = 1'b1;
    @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    #6 cpu_rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial forever begin
    exp_t e;
    @(posedge cpu_clk_50M);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("id_pc", id_pc, e.id_pc);
      chk("id_valid", 32'(id_valid), 32'(e.id_valid));
      chk("fetch_err", 32'(fetch_err), 32'(e.err));
    end
  end

  initial begin
    cpu_rst = 1'b1;
    stall = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    model_reset();
    #15 check_reset_state();
    @(negedge cpu_clk_50M);
    #3 cpu_rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0014);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b1, 32'h0000_0080);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, m_pc + 32'd4);
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic s, rv;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 9) < 2);
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      step(s, rv, t);
      if (i == 200) pulse_reset();
    end
    step(1'b0, 1'b1, 32'h0000_0022);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    pulse_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge cpu_clk_50M);
    #2 chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
